// File: rtl/memory_responder_pkg.sv
// Shared types and default sizes for the memory responder.
// Imported by the storage array and the control top.
package memory_responder_pkg;

  localparam int BITS_DATA_DEF = 32;
  localparam int BITS_ADDR_DEF = 16;
  localparam int DEPTH_DEF     = 65536;
  localparam int STORE_CNT_W   = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/memory_responder_mem_array.sv
// DEPTH x BITS_DATA storage: one async read port,
// one sync write port. Contents are never cleared.
module mem_array #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int DEPTH     = 65536
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [BITS_ADDR-1:0] i_waddr,
  input  logic [BITS_DATA-1:0] i_wdata,
  input  logic [BITS_ADDR-1:0] i_raddr,
  output logic [BITS_DATA-1:0] o_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITS_DATA-1:0] r_mem [DEPTH];
  logic [AW-1:0]        w_ra;
  logic [AW-1:0]        w_wa;
  logic                 w_unused_hi;

  // upper address bits are range-checked by the caller
  assign w_ra        = i_raddr[AW-1:0];
  assign w_wa        = i_waddr[AW-1:0];
  assign w_unused_hi = ^{i_raddr, i_waddr};

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_wa] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[w_ra];

endmodule

// File: rtl/memory_responder.sv
// CPU-facing memory target with a streaming preload port.
// Owns the run/load FSM, store edge detect, pointer and flags.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int BITS_DATA = BITS_DATA_DEF,
  parameter int BITS_ADDR = BITS_ADDR_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITS_ADDR-1:0]   MAR,
  input  logic [BITS_DATA-1:0]   MBR_W,
  input  logic                   write,
  output logic [BITS_DATA-1:0]   MBR_R,
  input  logic                   load_start,
  input  logic [BITS_ADDR-1:0]   load_base,
  input  logic [BITS_DATA-1:0]   load_data,
  input  logic                   load_valid,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   cpu_hold,
  output logic                   addr_err,
  output logic                   load_err,
  output logic [STORE_CNT_W-1:0] store_count
);

  localparam logic [BITS_ADDR:0] LAST_W =
    (BITS_ADDR+1)'(DEPTH - 1);

  state_t                 r_state;
  state_t                 w_state_nx;
  logic                   r_write_q;
  logic [BITS_ADDR-1:0]   r_mar_q;
  logic [BITS_ADDR-1:0]   r_ptr;
  logic                   r_addr_err;
  logic                   r_load_err;
  logic [STORE_CNT_W-1:0] r_store_count;

  logic                 w_run;
  logic                 w_load;
  logic                 w_in_range;
  logic                 w_ptr_end;
  logic                 w_ptr_ok;
  logic                 w_wr_edge;
  logic                 w_commit;
  logic                 w_xfer;
  logic                 w_mar_stable;
  logic                 w_addr_bad;
  logic                 w_overflow;
  logic                 w_we;
  logic [BITS_ADDR-1:0] w_waddr;
  logic [BITS_DATA-1:0] w_wdata;
  logic [BITS_DATA-1:0] w_rdata;

  assign w_run        = (r_state == ST_RUN);
  assign w_load       = (r_state == ST_LOAD);
  assign w_in_range   = ({1'b0, MAR} <= LAST_W);
  assign w_ptr_end    = ({1'b0, r_ptr} >= LAST_W);
  assign w_ptr_ok     = ({1'b0, r_ptr} <= LAST_W);
  assign w_wr_edge    = write & ~r_write_q;
  assign w_commit     = w_run & w_wr_edge & w_in_range;
  assign w_xfer       = w_load & load_valid;
  assign w_mar_stable = (MAR == r_mar_q);
  // a read counts once MAR has been held for a cycle
  assign w_addr_bad   = w_run & ~w_in_range
                      & (w_wr_edge | w_mar_stable);
  assign w_overflow   = w_xfer & w_ptr_end & ~load_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (load_start) begin
          w_state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_xfer & (load_last | w_ptr_end)) begin
          w_state_nx = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    cpu_hold   = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        load_ready = 1'b0;
        cpu_hold   = 1'b0;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_q     <= 1'b0;
      r_mar_q       <= '0;
      r_ptr         <= '0;
      r_addr_err    <= 1'b0;
      r_load_err    <= 1'b0;
      r_store_count <= '0;
    end else begin
      r_write_q <= write;
      r_mar_q   <= MAR;
      if (w_run & load_start) begin
        r_ptr <= load_base;
      end else if (w_xfer) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_commit) begin
        r_store_count <= r_store_count + 1'b1;
      end
      if (w_addr_bad) begin
        r_addr_err <= 1'b1;
      end
      if (w_overflow) begin
        r_load_err <= 1'b1;
      end
    end
  end

  // preload owns the write port whenever the FSM is in ST_LOAD
  assign w_we    = w_load ? (w_xfer & w_ptr_ok) : w_commit;
  assign w_waddr = w_load ? r_ptr : MAR;
  assign w_wdata = w_load ? load_data : MBR_W;

  mem_array #(
    .BITS_DATA (BITS_DATA),
    .BITS_ADDR (BITS_ADDR),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (MAR),
    .o_rdata (w_rdata)
  );

  assign MBR_R       = (w_run & w_in_range) ? w_rdata : '0;
  assign addr_err    = r_addr_err;
  assign load_err    = r_load_err;
  assign store_count = r_store_count;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with a 256-word array.
module tb_memory_responder;

  localparam int BD = 32;
  localparam int BA = 16;
  localparam int DP = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BA-1:0] MAR = '0;
  logic [BD-1:0] MBR_W = '0;
  logic          write = 1'b0;
  logic [BD-1:0] MBR_R;
  logic          load_start = 1'b0;
  logic [BA-1:0] load_base = '0;
  logic [BD-1:0] load_data = '0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          cpu_hold;
  logic          addr_err;
  logic          load_err;
  logic [15:0]   store_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_responder #(
    .BITS_DATA (BD),
    .BITS_ADDR (BA),
    .DEPTH     (DP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MAR         (MAR),
    .MBR_W       (MBR_W),
    .write       (write),
    .MBR_R       (MBR_R),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_hold    (cpu_hold),
    .addr_err    (addr_err),
    .load_err    (load_err),
    .store_count (store_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_aerr", 32'(addr_err), 32'd0);
    chk("rst_lerr", 32'(load_err), 32'd0);
    chk("rst_cnt", 32'(store_count), 32'd0);
    reset = 1'b0;
    step();

    // preload 3 words at 0x0010
    load_start = 1'b1;
    load_base  = 16'h0010;
    step();
    load_start = 1'b0;
    chk("pl_ready1", 32'(load_ready), 32'd1);
    chk("pl_hold1", 32'(cpu_hold), 32'd1);
    chk("pl_rd_zero", MBR_R, 32'd0);
    load_valid = 1'b1;
    load_data  = 32'hA1;
    step();
    chk("pl_ready2", 32'(load_ready), 32'd1);
    load_data = 32'hB2;
    step();
    chk("pl_ready3", 32'(load_ready), 32'd1);
    load_data = 32'hC3;
    load_last = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("pl_ready_end", 32'(load_ready), 32'd0);
    chk("pl_hold_end", 32'(cpu_hold), 32'd0);
    MAR = 16'h0011;
    #1 chk("pl_rd_11", MBR_R, 32'hB2);
    MAR = 16'h0010;
    #1 chk("pl_rd_10", MBR_R, 32'hA1);
    MAR = 16'h0012;
    #1 chk("pl_rd_12", MBR_R, 32'hC3);

    // store with write held 4 cycles
    MAR   = 16'h0040;
    MBR_W = 32'hDEADBEEF;
    write = 1'b1;
    step();
    chk("st1_cnt", 32'(store_count), 32'd1);
    chk("st1_rd", MBR_R, 32'hDEADBEEF);
    step();
    step();
    step();
    chk("st1_hold_cnt", 32'(store_count), 32'd1);
    write = 1'b0;
    step();

    // second store
    MAR   = 16'h0041;
    MBR_W = 32'd5;
    write = 1'b1;
    step();
    write = 1'b0;
    chk("st2_cnt", 32'(store_count), 32'd2);
    chk("st2_rd", MBR_R, 32'd5);
    MAR = 16'h0040;
    #1 chk("st2_old", MBR_R, 32'hDEADBEEF);
    step();

    // out-of-range store
    MAR   = 16'h0100;
    MBR_W = 32'h77;
    write = 1'b1;
    #1 chk("oor_rd", MBR_R, 32'd0);
    step();
    write = 1'b0;
    chk("oor_aerr", 32'(addr_err), 32'd1);
    chk("oor_cnt", 32'(store_count), 32'd2);
    MAR = 16'h0040;
    step();
    chk("oor_keep", MBR_R, 32'hDEADBEEF);

    // overflow preload with a CPU write during load
    load_start = 1'b1;
    load_base  = 16'h00FE;
    step();
    load_start = 1'b0;
    MAR        = 16'h0041;
    MBR_W      = 32'h99;
    write      = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h11;
    step();
    load_data = 32'h22;
    step();
    chk("ov_lerr", 32'(load_err), 32'd1);
    chk("ov_ready", 32'(load_ready), 32'd0);
    chk("ov_hold", 32'(cpu_hold), 32'd0);
    load_data = 32'h33;
    step();
    load_valid = 1'b0;
    write      = 1'b0;
    chk("ov_cnt", 32'(store_count), 32'd2);
    chk("ov_drop", MBR_R, 32'd5);
    MAR = 16'h00FE;
    #1 chk("ov_rd_fe", MBR_R, 32'h11);
    MAR = 16'h00FF;
    #1 chk("ov_rd_ff", MBR_R, 32'h22);
    step();

    // async reset after 2 of 4 words
    load_start = 1'b1;
    load_base  = 16'h0020;
    step();
    load_start = 1'b0;
    MAR        = 16'h0040;
    load_valid = 1'b1;
    load_data  = 32'h5A;
    #1 chk("rs_rd_load", MBR_R, 32'd0);
    step();
    load_data = 32'h6B;
    step();
    load_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rs_ready", 32'(load_ready), 32'd0);
    chk("rs_hold", 32'(cpu_hold), 32'd0);
    chk("rs_aerr", 32'(addr_err), 32'd0);
    chk("rs_lerr", 32'(load_err), 32'd0);
    chk("rs_cnt", 32'(store_count), 32'd0);
    step();
    reset = 1'b0;
    MAR   = 16'h0020;
    #1 chk("rs_rd_20", MBR_R, 32'h5A);
    MAR = 16'h0021;
    #1 chk("rs_rd_21", MBR_R, 32'h6B);
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
